// File: rtl/bound_flasher_gen.sv
// Bound flasher: a thermometer-coded lamp bar that sweeps up/down between fixed turn-around counts.
// Optional end-of-sequence blink is enabled by defining BOUND_FLASHER_GEN_BLINK_EN.
module bound_flasher_gen #(
  parameter int WIDTH = 16,
  parameter int MID1  = 5,
  parameter int MID2  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic             flick,
  output logic [WIDTH-1:0] light,
  output logic             busy,
  output logic [2:0]       phase
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_ZERO  = '0;
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_MID1  = CW'(MID1);
  localparam logic [CW-1:0] C_MID2  = CW'(MID2);
  localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);

`ifdef BOUND_FLASHER_GEN_BLINK_EN
  // Bit 3 only separates BLINK from KICK; both report phase 7.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0, ST_UP_FULL = 4'd1, ST_DOWN_MID1 = 4'd2, ST_UP_MID2 = 4'd3,
    ST_DOWN_ZERO = 4'd4, ST_UP_MID1 = 4'd5, ST_DOWN_END = 4'd6, ST_KICK = 4'd7,
    ST_BLINK = 4'd15
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_UP_FULL = 3'd1, ST_DOWN_MID1 = 3'd2, ST_UP_MID2 = 3'd3,
    ST_DOWN_ZERO = 3'd4, ST_UP_MID1 = 3'd5, ST_DOWN_END = 3'd6, ST_KICK = 3'd7
  } state_t;
`endif

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_count, w_count_nx;
  logic [WIDTH-1:0] r_light, w_light_nx;
  logic [CW-1:0]    w_up, w_dn;
`ifdef BOUND_FLASHER_GEN_BLINK_EN
  logic [1:0]       r_blk, w_blk_nx;
`endif

  function automatic logic [WIDTH-1:0] therm(input logic [CW-1:0] c);
    logic [WIDTH-1:0] t;
    for (int i = 0; i < WIDTH; i++) t[i] = (i < int'(c));
    return t;
  endfunction

  assign w_up = r_count + C_ONE;
  assign w_dn = r_count - C_ONE;

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_light_nx = r_light;
`ifdef BOUND_FLASHER_GEN_BLINK_EN
    w_blk_nx   = r_blk;
`endif
    if (step_en) begin
      case (r_state)
        ST_IDLE: begin
          if (flick) begin
            w_count_nx = C_ONE;
            w_state_nx = ST_UP_FULL;
          end
        end
        ST_UP_FULL: begin
          if (r_count == C_MID2 && flick) begin
            w_count_nx = w_dn;
            w_state_nx = ST_KICK;
          end else begin
            w_count_nx = w_up;
            if (w_up == C_WIDTH) w_state_nx = ST_DOWN_MID1;
          end
        end
        ST_KICK: begin
          w_count_nx = w_dn;
          if (w_dn == C_ZERO) w_state_nx = ST_UP_FULL;
        end
        ST_DOWN_MID1: begin
          w_count_nx = w_dn;
          if (w_dn == C_MID1) w_state_nx = ST_UP_MID2;
        end
        ST_UP_MID2: begin
          w_count_nx = w_up;
          if (w_up == C_MID2) w_state_nx = ST_DOWN_ZERO;
        end
        ST_DOWN_ZERO: begin
          w_count_nx = w_dn;
          if (w_dn == C_ZERO) w_state_nx = ST_UP_MID1;
        end
        ST_UP_MID1: begin
          w_count_nx = w_up;
          if (w_up == C_MID1) w_state_nx = ST_DOWN_END;
        end
        ST_DOWN_END: begin
          w_count_nx = w_dn;
          if (w_dn == C_ZERO) begin
`ifdef BOUND_FLASHER_GEN_BLINK_EN
            w_state_nx = ST_BLINK;
            w_blk_nx   = 2'd0;
`else
            w_state_nx = ST_IDLE;
`endif
          end
        end
`ifdef BOUND_FLASHER_GEN_BLINK_EN
        ST_BLINK: begin
          w_blk_nx = r_blk + 2'd1;
          if (r_blk == 2'd3) w_state_nx = ST_IDLE;
        end
`endif
        default: begin
          w_state_nx = ST_IDLE;
          w_count_nx = C_ZERO;
        end
      endcase
      w_light_nx = therm(w_count_nx);
`ifdef BOUND_FLASHER_GEN_BLINK_EN
      // Blink alternates full bar / dark while count stays parked at zero.
      if (r_state == ST_BLINK) w_light_nx = r_blk[0] ? '0 : '1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= C_ZERO;
      r_light <= '0;
`ifdef BOUND_FLASHER_GEN_BLINK_EN
      r_blk   <= 2'd0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_light <= w_light_nx;
`ifdef BOUND_FLASHER_GEN_BLINK_EN
      r_blk   <= w_blk_nx;
`endif
    end
  end

  assign light = r_light;
  assign busy  = (r_state != ST_IDLE);
  assign phase = r_state[2:0];
endmodule

// File: tb/tb_bound_flasher_gen.sv
// Bench for bound_flasher_gen: a leg-queue model of the sweep is checked every cycle,
// plus literal lamp patterns at the landmark steps of each directed scenario.
module tb_bound_flasher_gen;
  localparam int W  = 16;
  localparam int M1 = 5;
  localparam int M2 = 10;

  logic         clk = 1'b0;
  logic         reset, step_en, flick;
  logic [W-1:0] light;
  logic         busy;
  logic [2:0]   phase;

  bound_flasher_gen #(.WIDTH(W), .MID1(M1), .MID2(M2)) dut (
    .clk(clk), .reset(reset), .step_en(step_en), .flick(flick),
    .light(light), .busy(busy), .phase(phase)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: remaining sweep targets; the bar walks one lamp per step toward tgt[0].
  int           m_cnt = 0;
  int           tgt[$];
  int           blink_left = 0;
  logic [W-1:0] m_light = '0;

  function automatic logic [W-1:0] therm(input int c);
    logic [63:0] v;
    v = (64'd1 << c) - 64'd1;
    return v[W-1:0];
  endfunction

  function automatic void model_step(input logic r, input logic e, input logic f);
    if (r) begin
      tgt.delete();
      m_cnt = 0;
      blink_left = 0;
      m_light = '0;
      return;
    end
    if (!e) return;
    if (blink_left > 0) begin
      m_light = (blink_left == 4 || blink_left == 2) ? '1 : '0;
      blink_left--;
      return;
    end
    if (tgt.size() == 0) begin
      if (!f) return;
      tgt.push_back(W);  tgt.push_back(M1); tgt.push_back(M2);
      tgt.push_back(0);  tgt.push_back(M1); tgt.push_back(0);
    end else if (tgt.size() == 6 && m_cnt == M2 && f) begin
      tgt.push_front(0);
    end
    m_cnt += (tgt[0] > m_cnt) ? 1 : -1;
    if (m_cnt == tgt[0]) begin
      void'(tgt.pop_front());
`ifdef BOUND_FLASHER_GEN_BLINK_EN
      if (tgt.size() == 0) blink_left = 4;
`endif
    end
    m_light = therm(m_cnt);
  endfunction

  function automatic int exp_busy();
    return (tgt.size() > 0 || blink_left > 0) ? 1 : 0;
  endfunction

  function automatic int exp_phase();
    if (blink_left > 0 || tgt.size() == 7) return 7;
    if (tgt.size() == 0) return 0;
    return 7 - tgt.size();
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic f);
    reset = r; step_en = e; flick = f;
    @(posedge clk);
    model_step(r, e, f);
    @(negedge clk);
    check("light", {48'd0, light}, {48'd0, m_light});
    check("busy", {63'd0, busy}, 64'(exp_busy()));
    check("phase", {61'd0, phase}, 64'(exp_phase()));
  endtask

  initial begin
    reset = 1'b1; step_en = 1'b0; flick = 1'b0;

    // Reset, then idle steps without flick
    cycle(1, 0, 0);
    cycle(1, 1, 1);
    check("rst_light", {48'd0, light}, 64'h0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_phase", {61'd0, phase}, 64'd0);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0);
    check("idle_light", {48'd0, light}, 64'h0);

    // Single flick pulse through the whole sequence
    for (int s = 1; s <= 56; s++) begin
      cycle(0, 1, s == 1);
      case (s)
        1:  check("s1_light", {48'd0, light}, 64'h0001);
        16: check("s16_light", {48'd0, light}, 64'hFFFF);
        27: check("s27_light", {48'd0, light}, 64'h001F);
        32: check("s32_light", {48'd0, light}, 64'h03FF);
        42: check("s42_light", {48'd0, light}, 64'h0000);
        47: check("s47_light", {48'd0, light}, 64'h001F);
        52: begin
          check("s52_light", {48'd0, light}, 64'h0000);
`ifdef BOUND_FLASHER_GEN_BLINK_EN
          check("s52_busy", {63'd0, busy}, 64'd1);
`else
          check("s52_busy", {63'd0, busy}, 64'd0);
`endif
        end
`ifdef BOUND_FLASHER_GEN_BLINK_EN
        53: check("s53_light", {48'd0, light}, 64'hFFFF);
        54: check("s54_light", {48'd0, light}, 64'h0000);
        55: begin
          check("s55_light", {48'd0, light}, 64'hFFFF);
          check("s55_phase", {61'd0, phase}, 64'd7);
        end
        56: begin
          check("s56_light", {48'd0, light}, 64'h0000);
          check("s56_busy", {63'd0, busy}, 64'd0);
        end
`endif
        default: ;
      endcase
    end

    // Kickback at count 10
    cycle(1, 1, 0);
    for (int s = 1; s <= 36; s++) begin
      cycle(0, 1, s == 1 || s == 11);
      case (s)
        11: begin
          check("kick_light", {48'd0, light}, 64'h01FF);
          check("kick_phase", {61'd0, phase}, 64'd7);
        end
        20: begin
          check("kick0_light", {48'd0, light}, 64'h0000);
          check("kick0_phase", {61'd0, phase}, 64'd1);
        end
        36: check("kick16_light", {48'd0, light}, 64'hFFFF);
        default: ;
      endcase
    end

    // flick held high: repeated kickbacks
    cycle(1, 1, 0);
    for (int s = 1; s <= 70; s++) cycle(0, 1, 1);
    check("hold_busy", {63'd0, busy}, 64'd1);

    // flick ignored outside IDLE / UP_FULL@MID2
    cycle(1, 1, 0);
    for (int s = 1; s <= 52; s++) begin
      cycle(0, 1, s == 1 || s >= 17);
      if (s == 27) check("ign27_light", {48'd0, light}, 64'h001F);
      if (s == 32) check("ign32_light", {48'd0, light}, 64'h03FF);
    end

    // step_en low holds at count 12
    cycle(1, 1, 0);
    for (int s = 1; s <= 12; s++) cycle(0, 1, s == 1);
    for (int k = 0; k < 7; k++) begin
      cycle(0, 0, 1);
      check("hold_light", {48'd0, light}, 64'h0FFF);
    end
    cycle(0, 1, 0);
    check("resume_light", {48'd0, light}, 64'h1FFF);

    // Gapped step_en across a full sequence
    cycle(1, 1, 0);
    for (int s = 1; s <= 90; s++) cycle(0, (s % 3) != 0, s == 1);

    // Reset mid DOWN_MID1 at count 12, then restart
    cycle(1, 1, 0);
    for (int s = 1; s <= 20; s++) cycle(0, 1, s == 1);
    check("dm1_light", {48'd0, light}, 64'h0FFF);
    check("dm1_phase", {61'd0, phase}, 64'd2);
    cycle(1, 1, 1);
    check("mrst_light", {48'd0, light}, 64'h0000);
    check("mrst_phase", {61'd0, phase}, 64'd0);
    cycle(0, 1, 1);
    check("restart_light", {48'd0, light}, 64'h0001);
    check("restart_phase", {61'd0, phase}, 64'd1);
    cycle(0, 1, 0);
    check("restart2_light", {48'd0, light}, 64'h0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
